arm_multicycle_controller: RTL and testbench

Multicycle sequencer for the ARM-subset core. It replaces per-instruction combinational decode with a registered state machine that steps a shared datapath (one ALU, one unified memory port) through the fetch, decode, execute, memory and writeback phases. It holds the architectural NZCV flags and evaluates the condition field. It talks to memory through a request/ready handshake.

---
 rtl/arm_multicycle_controller.sv | 195 +++++++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_controller.sv
// rtl/arm_multicycle_controller.sv - multicycle sequencer for the ARM-subset core
// Steps the shared ALU/memory datapath through the instruction phases and owns NZCV.
module arm_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       LinkWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MOV = 2'b10;
  localparam logic [1:0] ALU_CMP = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic       dp_valid;
  logic [1:0] dp_alu;
  logic       n_f, z_f, c_f, v_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    case (Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = !z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = !c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = !n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = !v_f;
      4'b1000: cond_ex = c_f && !z_f;
      4'b1001: cond_ex = !c_f || z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = !z_f && (n_f == v_f);
      4'b1101: cond_ex = z_f || (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    dp_valid = 1'b1;
    dp_alu   = ALU_ADD;
    case (Funct[4:1])
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b1010: dp_alu = ALU_CMP;
      4'b1101: dp_alu = ALU_MOV;
      default: dp_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = S_FETCH;
    flags_d    = flags_q;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    LinkWrite  = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = 2'b00;
    ResultSrc  = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (cond_ex) begin
          case (Op)
            2'b00:   if (dp_valid) state_d = Funct[5] ? S_EXECI : S_EXECR;
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_EXECR, S_EXECI: begin
        ALUControl = dp_alu;
        if (state_q == S_EXECI) ALUSrcB = 2'b01;
        if (Funct[0] || dp_alu == ALU_CMP) flags_d = ALUFlags;
        state_d = (dp_alu == ALU_CMP) ? S_FETCH : S_ALUWB;
      end
      S_ALUWB, S_MEMWB: begin
        ResultSrc = (state_q == S_MEMWB) ? 2'b01 : 2'b00;
        if (Rd == 4'd15) PCWrite = 1'b1;
        else             RegWrite = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 2'b01;
        ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
        state_d    = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemReq  = 1'b1;
        AdrSrc  = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        state_d  = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        LinkWrite = Funct[4];
      end
      default: state_d = S_FETCH;
    endcase
    // Reset aborts any in-flight request: strobes and selects all read 0.
    if (reset) begin
      MemReq     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      LinkWrite  = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = 2'b00;
      ImmSrc     = 2'b00;
      ResultSrc  = 2'b00;
    end
  end

  assign Flags = flags_q;
  assign State = state_q;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// tb/tb_arm_multicycle_controller.sv - self-checking bench for arm_multicycle_controller
module tb_arm_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;
  logic       MemReq, MemWrite, IRWrite, PCWrite, RegWrite, LinkWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ALUControl, ImmSrc, ResultSrc;
  logic [3:0] Flags, State;

  arm_multicycle_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .LinkWrite(LinkWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .Flags(Flags), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] aluflags;
    int         waits;
    int         cyc;
    logic [3:0] flags;
    logic       rw;
    logic       pcw;
    logic       link;
    logic       memw;
    logic [1:0] alu;
  } vec_t;

  vec_t vt[16];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller must be at a negedge with State in FETCH.
  task automatic run_instr(input int idx);
    vec_t v, e;
    int   cycles, waits_left;
    logic seen_rw, seen_pcw, seen_link, seen_memw, fetch_ok;
    logic [1:0] seen_alu;
    v = vt[idx];
    Cond = v.cond; Op = v.op; Funct = v.funct; Rd = v.rd; ALUFlags = v.aluflags;
    sb.push_back(v);
    cycles = 0; waits_left = v.waits;
    seen_rw = 0; seen_pcw = 0; seen_link = 0; seen_memw = 0; fetch_ok = 1; seen_alu = 2'b00;
    while (cycles < 40) begin
      if (State == 4'd0) MemReady = 1'b1;
      else if (State == 4'd3 || State == 4'd5) begin
        if (waits_left > 0) begin MemReady = 1'b0; waits_left--; end
        else MemReady = 1'b1;
      end else MemReady = 1'b0;
      #1;
      if (State == 4'd0) begin
        fetch_ok &= IRWrite & PCWrite & MemReq & ALUSrcA & (ALUSrcB == 2'b10) & (ResultSrc == 2'b10);
      end else begin
        seen_pcw |= PCWrite;
        if (State == 4'd2 || State == 4'd6 || State == 4'd7) seen_alu = ALUControl;
      end
      seen_rw   |= RegWrite;
      seen_link |= LinkWrite;
      seen_memw |= MemWrite;
      cycles++;
      @(negedge clk);
      if (State == 4'd0) break;
    end
    e = sb.pop_front();
    check($sformatf("v%0d cycles", idx), cycles, e.cyc);
    check($sformatf("v%0d flags", idx), Flags, e.flags);
    check($sformatf("v%0d regwrite", idx), seen_rw, e.rw);
    check($sformatf("v%0d pcwrite", idx), seen_pcw, e.pcw);
    check($sformatf("v%0d linkwrite", idx), seen_link, e.link);
    check($sformatf("v%0d memwrite", idx), seen_memw, e.memw);
    check($sformatf("v%0d alucontrol", idx), seen_alu, e.alu);
    check($sformatf("v%0d fetch", idx), fetch_ok, 1);
  endtask

  initial begin
    //         cond   op     funct      rd     aluf   w cyc flags  rw pcw lk mw alu
    vt[0]  = '{4'hE, 2'b00, 6'b000101, 4'd1,  4'b0100, 0, 4, 4'b0100, 1, 0, 0, 0, 2'b01};
    vt[1]  = '{4'h0, 2'b00, 6'b101000, 4'd2,  4'b1000, 0, 4, 4'b0100, 1, 0, 0, 0, 2'b00};
    vt[2]  = '{4'h1, 2'b00, 6'b101000, 4'd2,  4'b1000, 0, 2, 4'b0100, 0, 0, 0, 0, 2'b00};
    vt[3]  = '{4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, 3, 8, 4'b0100, 0, 1, 0, 0, 2'b00};
    vt[4]  = '{4'hE, 2'b01, 6'b010001, 4'd3,  4'b0000, 0, 5, 4'b0100, 1, 0, 0, 0, 2'b01};
    vt[5]  = '{4'hE, 2'b10, 6'b010000, 4'd0,  4'b0000, 0, 3, 4'b0100, 0, 1, 1, 0, 2'b00};
    vt[6]  = '{4'hC, 2'b10, 6'b000000, 4'd0,  4'b0000, 0, 2, 4'b0100, 0, 0, 0, 0, 2'b00};
    vt[7]  = '{4'hE, 2'b00, 6'b110101, 4'd0,  4'b1001, 0, 3, 4'b1001, 0, 0, 0, 0, 2'b11};
    vt[8]  = '{4'hF, 2'b00, 6'b001000, 4'd1,  4'b0000, 0, 2, 4'b1001, 0, 0, 0, 0, 2'b00};
    vt[9]  = '{4'hE, 2'b11, 6'b000000, 4'd1,  4'b0000, 0, 2, 4'b1001, 0, 0, 0, 0, 2'b00};
    vt[10] = '{4'hE, 2'b01, 6'b011000, 4'd4,  4'b1111, 1, 5, 4'b1001, 0, 0, 0, 1, 2'b00};
    vt[11] = '{4'hE, 2'b00, 6'b111010, 4'd15, 4'b0110, 0, 4, 4'b1001, 0, 1, 0, 0, 2'b10};
    vt[12] = '{4'hE, 2'b00, 6'b000001, 4'd1,  4'b0110, 0, 2, 4'b1001, 0, 0, 0, 0, 2'b00};
    vt[13] = '{4'hA, 2'b00, 6'b001001, 4'd5,  4'b0010, 0, 4, 4'b0010, 1, 0, 0, 0, 2'b00};
    vt[14] = '{4'hB, 2'b00, 6'b001001, 4'd5,  4'b1111, 0, 2, 4'b0010, 0, 0, 0, 0, 2'b00};
    vt[15] = '{4'h8, 2'b10, 6'b000000, 4'd0,  4'b0000, 0, 3, 4'b0010, 0, 1, 0, 0, 2'b00};

    reset = 1'b1; Cond = 4'h0; Op = 2'b00; Funct = 6'b0; Rd = 4'd0;
    ALUFlags = 4'b0; MemReady = 1'b1;
    @(negedge clk);
    check("reset strobes", {MemReq, MemWrite, IRWrite, PCWrite, RegWrite, LinkWrite}, 0);
    check("reset selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 0);
    @(negedge clk);
    check("reset state", State, 0);
    check("reset flags", Flags, 0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_instr(i);

    // Reset in the middle of a stalled store
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd2; ALUFlags = 4'b1111;
    MemReady = 1'b1;
    @(negedge clk);
    MemReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("memwrite state", State, 5);
    check("memwrite strobe", {MemReq, MemWrite, AdrSrc}, 7);
    @(negedge clk);
    check("memwrite held", {MemReq, MemWrite, AdrSrc}, 7);
    reset = 1'b1;
    #1;
    check("reset mid-write strobes", {MemReq, MemWrite}, 0);
    @(negedge clk);
    reset = 1'b0;
    check("post-reset state", State, 0);
    check("post-reset flags", Flags, 0);
    MemReady = 1'b1;
    Cond = 4'hF;
    #1;
    check("post-reset fetch", {IRWrite, PCWrite}, 3);
    @(negedge clk);
    check("post-reset decode", State, 1);
    MemReady = 1'b0;
    #1;
    check("squash strobes", {MemReq, IRWrite, PCWrite, RegWrite}, 0);
    @(negedge clk);
    check("squash return", State, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
